des_reg_rx: RTL and testbench

DES_REG_RX -- requirements
Module: des_reg_rx

---
 rtl/des_reg_rx.sv | 133 +++++++++++++
 tb/tb_des_reg_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/des_reg_rx.sv
// Serial nibble receiver: start/data/parity/stop framing
// into a 2-entry FIFO with valid/ready read side.
module des_reg_rx #(
  parameter int PAR_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       dir,
  input  logic       s_in,
  input  logic       rdy,
  output logic [3:0] q,
  output logic       valid,
  output logic       err_par,
  output logic       err_frm,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t     r_state;
  logic [3:0] r_sh;
  logic [1:0] r_cnt;
  logic       r_dir;
  logic       r_bad;
  logic       r_err_par;
  logic       r_err_frm;
  logic       r_ovf;

  logic [3:0] r_mem [2];
  logic       r_wr;
  logic       r_rd;
  logic [1:0] r_fcnt;

  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_wr_ok;

  assign w_push  = enb && (r_state == STOP) && !s_in && !r_bad;
  assign w_pop   = rdy && (r_fcnt != 2'd0);
  assign w_full  = (r_fcnt == 2'd2);
  assign w_wr_ok = w_push && (!w_full || w_pop);

  assign q       = r_mem[r_rd];
  assign valid   = (r_fcnt != 2'd0);
  assign err_par = r_err_par;
  assign err_frm = r_err_frm;
  assign ovf     = r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sh      <= 4'd0;
      r_cnt     <= 2'd0;
      r_dir     <= 1'b0;
      r_bad     <= 1'b0;
      r_err_par <= 1'b0;
      r_err_frm <= 1'b0;
    end else if (enb) begin
      unique case (r_state)
        IDLE: begin
          if (s_in) begin
            r_state <= DATA;
            r_cnt   <= 2'd0;
            r_dir   <= dir;
            r_bad   <= 1'b0;
          end
        end
        DATA: begin
          if (r_dir)
            r_sh <= {s_in, r_sh[3:1]};
          else
            r_sh <= {r_sh[2:0], s_in};
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3)
            r_state <= (PAR_EN != 0) ? PAR : STOP;
        end
        PAR: begin
          if ((^r_sh) ^ s_in) begin
            r_err_par <= 1'b1;
            r_bad     <= 1'b1;
          end
          r_state <= STOP;
        end
        STOP: begin
          // A high stop bit doubles as the next frame's start bit
          if (s_in) begin
            r_err_frm <= 1'b1;
            r_state   <= DATA;
            r_cnt     <= 2'd0;
            r_dir     <= dir;
            r_bad     <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= 4'd0;
      r_mem[1] <= 4'd0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_fcnt   <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_mem[r_wr] <= r_sh;
        r_wr        <= ~r_wr;
      end else if (w_push) begin
        r_ovf <= 1'b1;
      end
      if (w_pop)
        r_rd <= ~r_rd;
      unique case ({w_wr_ok, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 2'd1;
        2'b01:   r_fcnt <= r_fcnt - 2'd1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_des_reg_rx.sv
// Directed self-checking bench for des_reg_rx.
// Frames are driven on negedge, outputs sampled 1ns after posedge.
module tb_des_reg_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enb = 1'b0;
  logic       dir = 1'b0;
  logic       s_in = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] q;
  logic       valid;
  logic       err_par;
  logic       err_frm;
  logic       ovf;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  des_reg_rx #(.PAR_EN(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .enb     (enb),
    .dir     (dir),
    .s_in    (s_in),
    .rdy     (rdy),
    .q       (q),
    .valid   (valid),
    .err_par (err_par),
    .err_frm (err_frm),
    .ovf     (ovf)
  );

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic gap);
    @(negedge clk);
    enb  = 1'b1;
    s_in = b;
    @(posedge clk);
    #1;
    enb  = 1'b0;
    s_in = 1'b0;
    if (gap) begin
      @(negedge clk);
      s_in = ~b;
      @(posedge clk);
      #1;
      s_in = 1'b0;
    end
  endtask

  task automatic send_body(input logic [3:0] d, input logic d_dir,
                           input logic bad_p, input logic stop_v,
                           input logic gap, input logic rs);
    dir = d_dir;
    for (int i = 0; i < 4; i++)
      send_bit(d_dir ? d[i] : d[3-i], gap);
    send_bit((^d) ^ bad_p, gap);
    rdy = rs;
    send_bit(stop_v, 1'b0);
    rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] d, input logic d_dir,
                            input logic bad_p, input logic stop_v,
                            input logic gap, input logic rs);
    dir = d_dir;
    send_bit(1'b1, gap);
    send_body(d, d_dir, bad_p, stop_v, gap, rs);
  endtask

  task automatic pop();
    @(negedge clk);
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("rst_all", {q, valid, err_par, err_frm, ovf}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_q", {4'd0, q}, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'h00);

    send_frame(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("msb_valid", {7'd0, valid}, 8'h01);
    check("msb_q", {4'd0, q}, 8'h0b);
    check("msb_err", {5'd0, err_par, err_frm, ovf}, 8'h00);
    pop();
    check("msb_pop", {7'd0, valid}, 8'h00);

    send_frame(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lsb_q", {3'd0, valid, q}, 8'h1d);
    pop();

    send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("par_err", {7'd0, err_par}, 8'h01);
    check("par_valid", {7'd0, valid}, 8'h00);

    do_reset();
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hold_q", {3'd0, valid, q}, 8'h1b);
    check("hold_ovf", {7'd0, ovf}, 8'h00);
    send_frame(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_set", {7'd0, ovf}, 8'h01);
    check("ovf_q", {3'd0, valid, q}, 8'h1b);
    pop();
    check("pop1_q", {3'd0, valid, q}, 8'h16);
    pop();
    check("pop2_empty", {7'd0, valid}, 8'h00);

    do_reset();
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("fullpp_ovf", {7'd0, ovf}, 8'h00);
    check("fullpp_q", {3'd0, valid, q}, 8'h16);
    pop();
    check("fullpp_q2", {3'd0, valid, q}, 8'h1f);
    pop();
    check("fullpp_empty", {7'd0, valid}, 8'h00);

    do_reset();
    send_frame(4'b1011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("frm_err", {7'd0, err_frm}, 8'h01);
    check("frm_valid", {7'd0, valid}, 8'h00);
    send_body(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("frm_next", {3'd0, valid, q}, 8'h16);

    do_reset();
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("gap_q", {3'd0, valid, q}, 8'h1b);
    check("gap_err", {5'd0, err_par, err_frm, ovf}, 8'h00);

    do_reset();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    do_reset();
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrst_q", {3'd0, valid, q}, 8'h16);
    check("midrst_err", {5'd0, err_par, err_frm, ovf}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
